sr_dmem_arb: RTL and testbench

- Data-memory access controller and arbiter for the single-cycle core.
- Takes the core's load/store requests, with the load/store width encoded in funct3 form, plus word-only requests from a debug/loader port, and shares one single-port data memory between them using round-robin arbitration.
- Generates byte enables and store-data lane placement, sign/zero-extends load data, and stalls the core until each access completes.
- Sits between the core datapath and the data memory.

---
 rtl/sr_dmem_arb_if.sv | 48 ++++
 rtl/sr_dmem_arb.sv | 230 +++++++++++++++++++++++
 tb/tb_sr_dmem_arb.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_dmem_arb_if.sv
// Signal bundle around the data-memory arbiter: core port, debug/loader port and memory side.
// The slave modport is the arbiter's view; master is the surrounding core/debug/memory view.
interface sr_dmem_arb_if #(
   parameter int ADDR_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [2:0]        cpu_mode;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_ack;
   logic              cpu_err;
   logic              cpu_stall;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [31:0]       dbg_wdata;
   logic [31:0]       dbg_rdata;
   logic              dbg_ack;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport slave (
      input  cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_err, cpu_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_rdata, dbg_ack,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport master (
      output cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_err, cpu_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_rdata, dbg_ack,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/sr_dmem_arb.sv
// Round-robin data-memory arbiter between the core load/store port and the debug/loader port.
// Build macro SR_DMEM_TIMEOUT_EN adds a mem_ack watchdog that aborts BUSY after TIMEOUT cycles.
//
// state | meaning
// IDLE  | no access in flight; arbitrates and latches the winning request
// BUSY  | memory access in flight, mem_req held with latched controls
// RESP  | one-cycle ack (and rdata/err) to the granted requester
module sr_dmem_arb #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic          clk,
   input logic          rst,
   sr_dmem_arb_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            stateQ, stateD;
   logic              lastGrantDbgQ, grantDbgQ, weQ, errQ;
   logic [2:0]        modeQ;
   logic [ADDR_W-1:0] addrQ;
   logic [31:0]       wdataQ, cpuRdataQ, dbgRdataQ;

   logic              cpuGrant, dbgGrant;
   logic              cpuIllegal, cpuMisalign, cpuBad;
   logic              timeoutHit;
   logic [3:0]        laneBe;
   logic [31:0]       laneWdata;

   logic              memReq, memWe, cpuAck, cpuErr, dbgAck;
   logic [ADDR_W-1:0] memAddr;
   logic [3:0]        memBe;
   logic [31:0]       memWdata;

   if (TIMEOUT < 2) begin : gTimeoutRange
      $error("sr_dmem_arb: TIMEOUT must be at least 2");
   end

   function automatic logic [31:0] loadExtend(input logic [2:0]  mode,
                                              input logic [1:0]  ofs,
                                              input logic [31:0] raw);
      logic [7:0]  byteSel;
      logic [15:0] halfSel;
      byteSel = 8'(raw >> {ofs, 3'b000});
      halfSel = 16'(raw >> {ofs[1], 4'b0000});
      case (mode)
         3'b000:  loadExtend = {{24{byteSel[7]}}, byteSel};
         3'b001:  loadExtend = {{16{halfSel[15]}}, halfSel};
         3'b100:  loadExtend = {24'd0, byteSel};
         3'b101:  loadExtend = {16'd0, halfSel};
         default: loadExtend = raw;
      endcase
   endfunction

   // Core request legality, judged on the live inputs at grant time.
   assign cpuIllegal  = (bus.cpu_mode == 3'b011) | (bus.cpu_mode[2:1] == 2'b11) |
                        (bus.cpu_we & bus.cpu_mode[2]);
   assign cpuMisalign = ((bus.cpu_mode[1:0] == 2'b01) & bus.cpu_addr[0]) |
                        ((bus.cpu_mode[1:0] == 2'b10) & (bus.cpu_addr[1:0] != 2'b00));
   assign cpuBad      = cpuIllegal | cpuMisalign;

`ifdef SR_DMEM_TIMEOUT_EN
   localparam int CntW = $clog2(TIMEOUT);

   logic [CntW-1:0] timeoutCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeoutCnt <= '0;
      end else if (stateQ != BUSY) begin
         timeoutCnt <= '0;
      end else if (!bus.mem_ack) begin
         timeoutCnt <= timeoutCnt + 1'b1;
      end
   end

   // A mem_ack in the terminal cycle still completes normally.
   assign timeoutHit = (stateQ == BUSY) & ~bus.mem_ack & (timeoutCnt == CntW'(TIMEOUT - 1));
`else
   assign timeoutHit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD   = stateQ;
      cpuGrant = 1'b0;
      dbgGrant = 1'b0;
      case (stateQ)
         IDLE: begin
            cpuGrant = bus.cpu_req & (~bus.dbg_req | lastGrantDbgQ);
            dbgGrant = bus.dbg_req & ~cpuGrant;
            if (cpuGrant) begin
               stateD = cpuBad ? RESP : BUSY;
            end else if (dbgGrant) begin
               stateD = BUSY;
            end
         end
         BUSY: begin
            if (bus.mem_ack || timeoutHit) begin
               stateD = RESP;
            end
         end
         RESP:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lastGrantDbgQ <= 1'b1;
         grantDbgQ     <= 1'b0;
         weQ           <= 1'b0;
         errQ          <= 1'b0;
         modeQ         <= 3'b000;
         addrQ         <= '0;
         wdataQ        <= '0;
         cpuRdataQ     <= '0;
         dbgRdataQ     <= '0;
      end else begin
         if (cpuGrant) begin
            lastGrantDbgQ <= 1'b0;
            grantDbgQ     <= 1'b0;
            weQ           <= bus.cpu_we;
            modeQ         <= bus.cpu_mode;
            addrQ         <= bus.cpu_addr;
            wdataQ        <= bus.cpu_wdata;
            errQ          <= cpuBad;
            if (cpuBad) begin
               cpuRdataQ <= '0;
            end
         end else if (dbgGrant) begin
            // Debug accesses are always words; mode is forced so lane logic passes data through.
            lastGrantDbgQ <= 1'b1;
            grantDbgQ     <= 1'b1;
            weQ           <= bus.dbg_we;
            modeQ         <= 3'b010;
            addrQ         <= bus.dbg_addr;
            wdataQ        <= bus.dbg_wdata;
            errQ          <= 1'b0;
         end

         if (stateQ == BUSY && bus.mem_ack) begin
            if (grantDbgQ) begin
               dbgRdataQ <= bus.mem_rdata;
            end else begin
               cpuRdataQ <= loadExtend(modeQ, addrQ[1:0], bus.mem_rdata);
            end
         end else if (timeoutHit) begin
            if (grantDbgQ) begin
               dbgRdataQ <= 32'hDEAD_BEEF;
            end else begin
               errQ      <= 1'b1;
               cpuRdataQ <= '0;
            end
         end
      end
   end

   always_comb begin
      laneBe    = 4'b1111;
      laneWdata = wdataQ;
      if (weQ) begin
         case (modeQ[1:0])
            2'b00: begin
               laneBe    = 4'b0001 << addrQ[1:0];
               laneWdata = {4{wdataQ[7:0]}};
            end
            2'b01: begin
               laneBe    = addrQ[1] ? 4'b1100 : 4'b0011;
               laneWdata = {2{wdataQ[15:0]}};
            end
            default: begin
               laneBe    = 4'b1111;
               laneWdata = wdataQ;
            end
         endcase
      end else begin
         laneWdata = '0;
      end
   end

   always_comb begin
      memReq   = 1'b0;
      memWe    = 1'b0;
      memAddr  = '0;
      memBe    = 4'b0000;
      memWdata = '0;
      cpuAck   = 1'b0;
      cpuErr   = 1'b0;
      dbgAck   = 1'b0;
      case (stateQ)
         BUSY: begin
            memReq   = 1'b1;
            memWe    = weQ;
            memAddr  = {addrQ[ADDR_W-1:2], 2'b00};
            memBe    = laneBe;
            memWdata = laneWdata;
         end
         RESP: begin
            cpuAck = ~grantDbgQ;
            cpuErr = ~grantDbgQ & errQ;
            dbgAck = grantDbgQ;
         end
         default: ;
      endcase
   end

   assign bus.mem_req   = memReq;
   assign bus.mem_we    = memWe;
   assign bus.mem_addr  = memAddr;
   assign bus.mem_be    = memBe;
   assign bus.mem_wdata = memWdata;
   assign bus.cpu_ack   = cpuAck;
   assign bus.cpu_err   = cpuErr;
   assign bus.cpu_rdata = cpuRdataQ;
   assign bus.cpu_stall = bus.cpu_req & ~cpuAck;
   assign bus.dbg_ack   = dbgAck;
   assign bus.dbg_rdata = dbgRdataQ;
endmodule

// File: tb/tb_sr_dmem_arb.sv
// Directed bench for sr_dmem_arb: core vector table, debug accesses, round-robin,
// reset mid-access and, when SR_DMEM_TIMEOUT_EN is defined, the mem_ack watchdog.
module tb_sr_dmem_arb;
   logic clk;
   logic rst;

   sr_dmem_arb_if #(.ADDR_W(32)) bus ();

   sr_dmem_arb #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        we;
      logic [2:0]  mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] memRd;
      logic        expErr;
      logic [31:0] expAddr;
      logic [3:0]  expBe;
      logic [31:0] expWdata;
      logic [31:0] expRdata;
      logic        chkRd;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   int tests = 0;
   int fails = 0;

   int          memLat    = 1;
   bit          memHold   = 1'b0;
   logic [31:0] memData   = '0;
   int          memCnt    = 0;
   int          reqCycles = 0;
   logic        capWe     = 1'b0;
   logic [31:0] capAddr   = '0;
   logic [31:0] capWdata  = '0;
   logic [3:0]  capBe     = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: acks after memLat cycles of mem_req unless memHold; records the request.
   always @(negedge clk) begin
      if (bus.mem_req) begin
         memCnt    = memCnt + 1;
         reqCycles = reqCycles + 1;
         if (!memHold && memCnt >= memLat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = memData;
            capWe         = bus.mem_we;
            capAddr       = bus.mem_addr;
            capBe         = bus.mem_be;
            capWdata      = bus.mem_wdata;
         end else begin
            bus.mem_ack = 1'b0;
         end
      end else begin
         memCnt      = 0;
         bus.mem_ack = 1'b0;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic runCpu(input vec_t v, input int idx);
      int cyc;
      int reqBefore;
      bit stallOk;
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = v.we;
      bus.cpu_mode  = v.mode;
      bus.cpu_addr  = v.addr;
      bus.cpu_wdata = v.wdata;
      memData       = v.memRd;
      reqBefore     = reqCycles;
      cyc           = 0;
      stallOk       = 1'b1;
      do begin
         @(negedge clk);
         cyc++;
         if (!bus.cpu_ack && !bus.cpu_stall) stallOk = 1'b0;
      end while (!bus.cpu_ack && cyc < 20);
      check($sformatf("cpu%0d ack_cycle", idx), 32'(cyc), v.expErr ? 32'd1 : 32'(1 + memLat));
      check($sformatf("cpu%0d err", idx), 32'(bus.cpu_err), 32'(v.expErr));
      check($sformatf("cpu%0d stall_wait", idx), 32'(stallOk), 32'd1);
      check($sformatf("cpu%0d stall_at_ack", idx), 32'(bus.cpu_stall), 32'd0);
      check($sformatf("cpu%0d dbg_ack", idx), 32'(bus.dbg_ack), 32'd0);
      if (v.chkRd) check($sformatf("cpu%0d rdata", idx), bus.cpu_rdata, v.expRdata);
      if (v.expErr) begin
         check($sformatf("cpu%0d no_mem", idx), 32'(reqCycles - reqBefore), 32'd0);
      end else begin
         check($sformatf("cpu%0d mem_addr", idx), capAddr, v.expAddr);
         check($sformatf("cpu%0d mem_be", idx), 32'(capBe), 32'(v.expBe));
         check($sformatf("cpu%0d mem_we", idx), 32'(capWe), 32'(v.we));
         if (v.we) check($sformatf("cpu%0d mem_wdata", idx), capWdata, v.expWdata);
      end
      bus.cpu_req = 1'b0;
      @(negedge clk);
      check($sformatf("cpu%0d ack_pulse", idx), 32'(bus.cpu_ack), 32'd0);
      if (v.chkRd) check($sformatf("cpu%0d rdata_hold", idx), bus.cpu_rdata, v.expRdata);
   endtask

   task automatic runDbg(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] memRd, input logic [31:0] expAddr,
                         input logic [31:0] expRdata, input string nm);
      int cyc;
      @(negedge clk);
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = we;
      bus.dbg_addr  = addr;
      bus.dbg_wdata = wdata;
      memData       = memRd;
      cyc           = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.dbg_ack && cyc < 20);
      check({nm, " ack_cycle"}, 32'(cyc), 32'(1 + memLat));
      check({nm, " cpu_ack"}, 32'(bus.cpu_ack), 32'd0);
      check({nm, " mem_addr"}, capAddr, expAddr);
      check({nm, " mem_be"}, 32'(capBe), 32'hF);
      check({nm, " mem_we"}, 32'(capWe), 32'(we));
      if (we) check({nm, " mem_wdata"}, capWdata, wdata);
      else    check({nm, " rdata"}, bus.dbg_rdata, expRdata);
      bus.dbg_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int   cyc;
      int   got;
      int   lastAck;
      bit   stallOk;
      vec_t recov;

      //           we    mode    addr     wdata         memRd         err   expAddr  be       expWdata      expRdata      chkRd
      vecs[0]  = '{1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0,        1'b0, 32'h100, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 3'b001, 32'h202, 32'h0,         32'h8001_7FFF, 1'b0, 32'h200, 4'b1111, 32'h0,         32'hFFFF_8001, 1'b1};
      vecs[2]  = '{1'b0, 3'b101, 32'h202, 32'h0,         32'h8001_7FFF, 1'b0, 32'h200, 4'b1111, 32'h0,         32'h0000_8001, 1'b1};
      vecs[3]  = '{1'b0, 3'b010, 32'h301, 32'h0,         32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,         32'h0,        1'b1};
      vecs[4]  = '{1'b0, 3'b011, 32'h300, 32'h0,         32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,         32'h0,        1'b1};
      vecs[5]  = '{1'b0, 3'b000, 32'h401, 32'h0,         32'h1234_80FF, 1'b0, 32'h400, 4'b1111, 32'h0,         32'hFFFF_FF80, 1'b1};
      vecs[6]  = '{1'b0, 3'b100, 32'h403, 32'h0,         32'h1234_80FF, 1'b0, 32'h400, 4'b1111, 32'h0,         32'h0000_0012, 1'b1};
      vecs[7]  = '{1'b0, 3'b010, 32'h500, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h500, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b1};
      vecs[8]  = '{1'b1, 3'b001, 32'h602, 32'h1234_BEEF, 32'h0,        1'b0, 32'h600, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0};
      vecs[9]  = '{1'b1, 3'b010, 32'h704, 32'h1122_3344, 32'h0,        1'b0, 32'h704, 4'b1111, 32'h1122_3344, 32'h0,        1'b0};
      vecs[10] = '{1'b1, 3'b100, 32'h800, 32'h0000_0055, 32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,         32'h0,        1'b1};
      vecs[11] = '{1'b0, 3'b001, 32'h801, 32'h0,         32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,         32'h0,        1'b1};
      vecs[12] = '{1'b1, 3'b000, 32'h900, 32'hFFFF_FF3C, 32'h0,        1'b0, 32'h900, 4'b0001, 32'h3C3C_3C3C, 32'h0,        1'b0};
      vecs[13] = '{1'b0, 3'b000, 32'h402, 32'h0,         32'h007F_0000, 1'b0, 32'h400, 4'b1111, 32'h0,         32'h0000_007F, 1'b1};

      rst           = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_mode  = 3'b000;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.dbg_req   = 1'b0;
      bus.dbg_we    = 1'b0;
      bus.dbg_addr  = '0;
      bus.dbg_wdata = '0;
      repeat (2) @(negedge clk);
      check("reset mem_req", 32'(bus.mem_req), 32'd0);
      check("reset mem_be", 32'(bus.mem_be), 32'd0);
      check("reset mem_addr", bus.mem_addr, 32'd0);
      check("reset cpu_ack", 32'(bus.cpu_ack), 32'd0);
      check("reset cpu_err", 32'(bus.cpu_err), 32'd0);
      check("reset dbg_ack", 32'(bus.dbg_ack), 32'd0);
      check("reset cpu_rdata", bus.cpu_rdata, 32'd0);
      check("reset dbg_rdata", bus.dbg_rdata, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) runCpu(vecs[i], i);

      runDbg(1'b0, 32'hA03, 32'h0, 32'h89AB_CDEF, 32'hA00, 32'h89AB_CDEF, "dbg_rd");
      runDbg(1'b1, 32'hA06, 32'h0BAD_F00D, 32'h0, 32'hA04, 32'h0, "dbg_wr");

      // Both requesters held from reset, 2-cycle memory: CPU, DBG, CPU, DBG, four cycles apart.
      @(negedge clk);
      rst           = 1'b1;
      memLat        = 2;
      memData       = 32'h5555_AAAA;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_mode  = 3'b010;
      bus.cpu_addr  = 32'h10;
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b0;
      bus.dbg_addr  = 32'h20;
      @(negedge clk);
      rst     = 1'b0;
      got     = 0;
      cyc     = 0;
      lastAck = 0;
      stallOk = 1'b1;
      while (got < 4 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (!bus.cpu_ack && !bus.cpu_stall) stallOk = 1'b0;
         if (bus.cpu_ack || bus.dbg_ack) begin
            check($sformatf("rr%0d one_ack", got), 32'(bus.cpu_ack & bus.dbg_ack), 32'd0);
            check($sformatf("rr%0d is_dbg", got), 32'(bus.dbg_ack), 32'(got % 2));
            if (got == 0) check("rr0 ack_cycle", 32'(cyc), 32'd3);
            else          check($sformatf("rr%0d gap", got), 32'(cyc - lastAck), 32'd4);
            if (bus.cpu_ack) check($sformatf("rr%0d stall_at_ack", got), 32'(bus.cpu_stall), 32'd0);
            lastAck = cyc;
            got++;
         end
      end
      check("rr acks_seen", 32'(got), 32'd4);
      check("rr stall_wait", 32'(stallOk), 32'd1);
      bus.cpu_req = 1'b0;
      bus.dbg_req = 1'b0;
      @(negedge clk);
      memLat = 1;

      // Reset in BUSY with mem_ack withheld drops everything at once; next access is normal.
      memHold = 1'b1;
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_mode = 3'b010;
      bus.cpu_addr = 32'hB00;
      repeat (2) @(negedge clk);
      check("abort busy mem_req", 32'(bus.mem_req), 32'd1);
      rst         = 1'b1;
      bus.cpu_req = 1'b0;
      #1;
      check("abort mem_req", 32'(bus.mem_req), 32'd0);
      check("abort cpu_ack", 32'(bus.cpu_ack), 32'd0);
      check("abort dbg_ack", 32'(bus.dbg_ack), 32'd0);
      @(negedge clk);
      rst     = 1'b0;
      memHold = 1'b0;
      recov   = '{1'b0, 3'b010, 32'hB00, 32'h0, 32'h0F0F_1234, 1'b0, 32'hB00, 4'b1111, 32'h0, 32'h0F0F_1234, 1'b1};
      runCpu(recov, 100);

`ifdef SR_DMEM_TIMEOUT_EN
      // Watchdog with TIMEOUT=4: four BUSY cycles then an error/poison response.
      memHold = 1'b1;
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_mode = 3'b010;
      bus.cpu_addr = 32'hC00;
      got = 0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (bus.mem_req) got++;
      end while (!bus.cpu_ack && cyc < 40);
      check("to_cpu busy_cycles", 32'(got), 32'd4);
      check("to_cpu ack", 32'(bus.cpu_ack), 32'd1);
      check("to_cpu err", 32'(bus.cpu_err), 32'd1);
      check("to_cpu rdata", bus.cpu_rdata, 32'd0);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      bus.dbg_req  = 1'b1;
      bus.dbg_we   = 1'b0;
      bus.dbg_addr = 32'hC04;
      got = 0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (bus.mem_req) got++;
      end while (!bus.dbg_ack && cyc < 40);
      check("to_dbg busy_cycles", 32'(got), 32'd4);
      check("to_dbg ack", 32'(bus.dbg_ack), 32'd1);
      check("to_dbg rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
      bus.dbg_req = 1'b0;
      @(negedge clk);
      memHold = 1'b0;
      memLat  = 4;
      recov   = '{1'b0, 3'b010, 32'hC08, 32'h0, 32'h1357_9BDF, 1'b0, 32'hC08, 4'b1111, 32'h0, 32'h1357_9BDF, 1'b1};
      runCpu(recov, 101);
      memLat = 1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
